bwt_last_column_out: RTL and testbench

//  Consumes the sorted rotation matrix from merge_sort_top and produces the BWT result:

---
 rtl/bwt_last_column_out.sv | 189 ++++++++++++++++++
 tb/tb_bwt_last_column_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_last_column_out.sv
// BWT output stage: streams the last column of the sorted rotation matrix
// and reports the primary index (sorted row holding rotation 0).
//
// Ports:
//   clk, rst         clock, async active-low reset
//   text_load        capture text_in (IDLE only)
//   text_in          original text, byte 0 first
//   sorted           completion flag from the sort stage (rising edge starts)
//   data_in          sorted matrix from the sort stage
//   out_data/valid/ready/last  last-column byte stream, valid/ready handshake
//   primary_idx      sorted row whose index byte is 0
//   done             1-cycle pulse after the last beat is accepted
//   busy             not idle
//   err              sticky: [0] index out of range, [1] duplicate index,
//                    [2] sorted rose while busy
module bwt_last_column_out #(
    parameter int  COLUMN     = 3,
    parameter int  STRING_LEN = 8,
    parameter int  IDX_COL    = 0,
    localparam int IDXW       = $clog2(STRING_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            text_load,
    input  logic [7:0]      text_in [0:STRING_LEN-1],
    input  logic            sorted,
    input  logic [7:0]      data_in [0:STRING_LEN-1][COLUMN-1:0],
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [IDXW-1:0] primary_idx,
    output logic            done,
    output logic            busy,
    output logic [2:0]      err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(STRING_LEN - 1);
    localparam logic [8:0]      LEN9     = 9'(STRING_LEN);

    state_t state;
    state_t state_nxt;

    logic [7:0]            text    [0:STRING_LEN-1];
    logic [7:0]            idx_mat [0:STRING_LEN-1];
    logic [STRING_LEN-1:0] seen;
    logic [IDXW-1:0]       row;
    logic                  sorted_q;

    logic            sort_rise;
    logic            accept;
    logic            last_row;
    logic [7:0]      cur_byte;
    logic [IDXW-1:0] cur_idx;
    logic [IDXW-1:0] src;
    logic            bad;
    logic [2:0]      err_nxt;
    logic            unused_cols;

    assign sort_rise = sorted & ~sorted_q;
    assign last_row  = (row == LAST_ROW);
    assign accept    = (state == ST_STREAM) & out_ready;

    // The byte before rotation idx in the text is its last-column byte.
    always_comb begin
        cur_byte = idx_mat[row];
        cur_idx  = cur_byte[IDXW-1:0];
        bad      = ({1'b0, cur_byte} >= LEN9);
        src      = (cur_idx == '0) ? LAST_ROW : cur_idx - IDXW'(1);
        out_data = 8'h00;
        if (state == ST_STREAM && !bad) begin
            out_data = text[src];
        end
    end

    // Only the index column of the matrix is needed here.
    always_comb begin
        unused_cols = 1'b0;
        for (int r = 0; r < STRING_LEN; r++) begin
            for (int c = 0; c < COLUMN; c++) begin
                if (c != IDX_COL) begin
                    unused_cols = unused_cols ^ (^data_in[r][c]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (sort_rise) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_last  = last_row;
                if (out_ready && last_row) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Errors clear on the ARM capture; a late sorted edge still flags.
    always_comb begin
        err_nxt = (state == ST_ARM) ? 3'b000 : err;
        if (accept && bad) begin
            err_nxt[0] = 1'b1;
        end
        if (accept && seen[cur_idx]) begin
            err_nxt[1] = 1'b1;
        end
        if (sort_rise && state != ST_IDLE) begin
            err_nxt[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sorted_q    <= 1'b0;
            row         <= '0;
            primary_idx <= '0;
            err         <= 3'b000;
            seen        <= '0;
            for (int i = 0; i < STRING_LEN; i++) begin
                text[i]    <= 8'h00;
                idx_mat[i] <= 8'h00;
            end
        end else begin
            sorted_q <= sorted;
            err      <= err_nxt;
            if (state == ST_IDLE && text_load) begin
                for (int i = 0; i < STRING_LEN; i++) begin
                    text[i] <= text_in[i];
                end
            end
            if (state == ST_ARM) begin
                for (int i = 0; i < STRING_LEN; i++) begin
                    idx_mat[i] <= data_in[i][IDX_COL];
                end
                row         <= '0;
                seen        <= '0;
                primary_idx <= '0;
            end
            if (accept) begin
                seen[cur_idx] <= 1'b1;
                if (cur_byte == 8'h00) begin
                    primary_idx <= row;
                end
                if (!last_row) begin
                    row <= row + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bwt_last_column_out.sv
// Testbench for bwt_last_column_out: scoreboard of expected last-column
// beats, handshake stalls, error flags, async reset abort.
module tb_bwt_last_column_out;

    localparam int N   = 8;
    localparam int COL = 3;
    localparam int IC  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       text_load = 1'b0;
    logic       sorted = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] text_in [0:N-1];
    logic [7:0] data_in [0:N-1][COL-1:0];
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [2:0] primary_idx;
    logic       done;
    logic       busy;
    logic [2:0] err;

    bwt_last_column_out #(
        .COLUMN    (COL),
        .STRING_LEN(N),
        .IDX_COL   (IC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .text_load  (text_load),
        .text_in    (text_in),
        .sorted     (sorted),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .primary_idx(primary_idx),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] t_text [0:N-1];
    logic [7:0] t_idx  [0:N-1];
    logic [8:0] sb [$];
    int         exp_pidx;
    int         beats;
    bit         saw_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_t1();
        for (int r = 0; r < N; r++) begin
            t_text[r] = 8'h10 + 8'(r);
            t_idx[r]  = 8'(N - 1 - r);
        end
    endtask

    // Drive text + matrix, push expected beats, raise sorted.
    task automatic start_sort();
        int         j;
        logic [2:0] lo;
        logic [7:0] b;
        sb.delete();
        exp_pidx = 0;
        for (int r = 0; r < N; r++) begin
            text_in[r] = t_text[r];
            for (int c = 0; c < COL; c++) begin
                data_in[r][c] = (c == IC) ? t_idx[r]
                                          : 8'($urandom_range(0, 255));
            end
            lo = t_idx[r][2:0];
            j  = (lo == 3'd0) ? N - 1 : int'(lo) - 1;
            b  = (t_idx[r] >= 8'(N)) ? 8'h00 : t_text[j];
            sb.push_back({(r == N - 1), b});
            if (t_idx[r] == 8'h00) exp_pidx = r;
        end
        text_load = 1'b1;
        sorted    = 1'b1;
        @(posedge clk);
        #1;
        text_load = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_valid", out_valid, 0);
    endtask

    // mode 0: ready=1; 1: ready toggles; 2: ready=1 plus late sorted
    // rise and ignored text_load mid-stream.
    task automatic run_stream(input int mode, input int abort_at,
                              output int nb, output bit sd);
        bit         stall;
        bit         fin;
        logic [7:0] hd;
        logic       hl;
        logic [8:0] e;
        nb = 0;
        sd = 1'b0;
        stall = 1'b0;
        fin = 1'b0;
        hd = 8'h00;
        hl = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                sd  = 1'b1;
                fin = 1'b1;
            end else if (abort_at > 0 && nb == abort_at) begin
                fin = 1'b1;
            end else begin
                if (mode == 2) begin
                    if (cyc == 1) sorted = 1'b0;
                    if (cyc == 3) begin
                        sorted    = 1'b1;
                        text_load = 1'b1;
                        for (int r = 0; r < N; r++) text_in[r] = 8'hEE;
                    end
                    if (cyc == 4) text_load = 1'b0;
                end
                if (out_valid) begin
                    if (stall) begin
                        check("hold_data", out_data, hd);
                        check("hold_last", out_last, hl);
                    end
                    out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            check("sb_under", sb.size(), 1);
                        end else begin
                            e = sb.pop_front();
                            check("beat_data", out_data, e[7:0]);
                            check("beat_last", out_last, e[8]);
                        end
                        nb++;
                        stall = 1'b0;
                    end else begin
                        stall = 1'b1;
                        hd = out_data;
                        hl = out_last;
                    end
                end
            end
        end
        if (!fin) check("timeout", sd, 1);
    endtask

    task automatic finish_run(input string nm, input int nb, input bit sd,
                              input logic [2:0] emask,
                              input logic [2:0] eerr);
        check({nm, "_done"}, sd, 1);
        check({nm, "_beats"}, nb, N);
        check({nm, "_pidx"}, primary_idx, exp_pidx);
        check({nm, "_err"}, err & emask, eerr);
        check({nm, "_sb"}, sb.size(), 0);
        @(posedge clk);
        #1;
        check({nm, "_done1"}, done, 0);
        check({nm, "_idle"}, busy, 0);
        sorted = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            text_in[r] = 8'h00;
            for (int c = 0; c < COL; c++) data_in[r][c] = 8'h00;
        end
        #1 rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_pidx", primary_idx, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // T1
        set_t1();
        start_sort();
        run_stream(0, 0, beats, saw_done);
        finish_run("t1", beats, saw_done, 3'b111, 3'b000);

        // T2
        set_t1();
        start_sort();
        run_stream(1, 0, beats, saw_done);
        finish_run("t2", beats, saw_done, 3'b111, 3'b000);

        // T3 duplicate index
        set_t1();
        for (int r = 0; r < N; r++) t_idx[r] = 8'(r);
        t_idx[1] = 8'h00;
        start_sort();
        run_stream(0, 0, beats, saw_done);
        finish_run("t3", beats, saw_done, 3'b011, 3'b010);

        // T4 out-of-range index on row 3
        set_t1();
        t_idx[3] = 8'd9;
        start_sort();
        run_stream(0, 0, beats, saw_done);
        finish_run("t4", beats, saw_done, 3'b001, 3'b001);

        // T5 late sorted rise, then a clean restart clears err
        set_t1();
        start_sort();
        run_stream(2, 0, beats, saw_done);
        finish_run("t5", beats, saw_done, 3'b111, 3'b100);
        set_t1();
        start_sort();
        run_stream(0, 0, beats, saw_done);
        finish_run("t5b", beats, saw_done, 3'b111, 3'b000);

        // Random permutation and text
        for (int r = 0; r < N; r++) begin
            t_text[r] = 8'($urandom_range(0, 255));
            t_idx[r]  = 8'(r);
        end
        for (int r = N - 1; r > 0; r--) begin
            int         k;
            logic [7:0] tmp;
            k = $urandom_range(0, r);
            tmp = t_idx[r];
            t_idx[r] = t_idx[k];
            t_idx[k] = tmp;
        end
        start_sort();
        run_stream(1, 0, beats, saw_done);
        finish_run("rnd", beats, saw_done, 3'b111, 3'b000);

        // T6 async reset mid-stream
        set_t1();
        start_sort();
        run_stream(0, 4, beats, saw_done);
        check("t6_beats", beats, 4);
        #2 rst = 1'b0;
        sorted = 1'b0;
        out_ready = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_last", out_last, 0);
        check("t6_data", out_data, 0);
        @(posedge clk);
        #1;
        check("t6_nodone", done, 0);
        @(negedge clk) rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("t6_pidx_rst", primary_idx, 0);
        set_t1();
        start_sort();
        run_stream(0, 0, beats, saw_done);
        finish_run("t6b", beats, saw_done, 3'b111, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
